fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the core's decode/execute datapath. It owns the program counter, issues sequential reads to the synchronous instruction memory (fixed 1-cycle read latency), and buffers the returned words in a small prefetch FIFO. It hands {instruction, pc} to the core over a valid/ready handshake. A redirect from branch/jump resolution flushes the FIFO and any in-flight read.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential 1-cycle-latency reads
// and buffers returned words in a fall-through prefetch FIFO for the core.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] count_q, count_d;

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [OW:0]   inflight;
  logic          issue;
  logic          push;
  logic          pop;
  logic          redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Credit counts buffered words plus the read still in flight; a same-cycle
  // pop is deliberately not credited so the request path stays short.
  assign inflight = {1'b0, count_q} + {{OW{1'b0}}, pending_q};
  assign issue    = rst && !redirect_valid && (inflight < (OW+1)'(DEPTH));
  assign push     = pending_q && !redirect_valid;
  assign pop      = inst_valid && inst_ready;

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];
  assign occupancy  = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      pending_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pend_pc_d  = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OW'(1);
        2'b01:   count_d = count_q - OW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

  noPushWhenFull: assert property (@(posedge clk) disable iff (!rst)
    !(push && count_q == OW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the prefetch behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [2:0]  occupancy;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Model: FIFO contents as {data, pc}, plus the single in-flight read.
  logic [63:0] mQ[$];
  bit          mPend;
  logic [31:0] mPpc;
  logic [31:0] mFpc;

  logic        lastReq;
  logic [31:0] lastAddr;

  logic        sReq, sValid;
  logic [31:0] sAddr, sPc, sData;
  logic [2:0]  sOcc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPend    = 1'b0;
    mPpc     = '0;
    mFpc     = RESET_PC;
    lastReq  = 1'b0;
    lastAddr = '0;
  endtask

  task automatic checkOutput();
    bit expReq;
    expReq = !redirect_valid && (mQ.size() + int'(mPend) < DEPTH);
    check32("imem_req",   32'(imem_req),   32'(expReq));
    check32("imem_addr",  imem_addr,       mFpc);
    check32("inst_valid", 32'(inst_valid), 32'(mQ.size() != 0));
    check32("occupancy",  32'(occupancy),  32'(mQ.size()));
    if (mQ.size() != 0 && inst_valid === 1'b1) begin
      check32("inst_data", inst_data, mQ[0][63:32]);
      check32("inst_pc",   inst_pc,   mQ[0][31:0]);
    end
  endtask

  // One clock cycle: drive inputs at the negedge, check, advance the model.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    bit issue;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rdata     = lastReq ? ~lastAddr : $urandom();
    #1;
    checkOutput();
    sReq   = imem_req;
    sAddr  = imem_addr;
    sValid = inst_valid;
    sPc    = inst_pc;
    sData  = inst_data;
    sOcc   = occupancy;
    lastReq  = imem_req;
    lastAddr = imem_addr;

    issue = !redir && (mQ.size() + int'(mPend) < DEPTH);
    if (redir) begin
      mQ.delete();
      mPend = 1'b0;
      mFpc  = {rpc[31:2], 2'b00};
    end else begin
      if (mQ.size() != 0 && rdy) void'(mQ.pop_front());
      if (mPend) mQ.push_back({imem_rdata, mPpc});
      mPend = issue;
      if (issue) begin
        mPpc = mFpc;
        mFpc = mFpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    modelReset();
    check32("rst_imem_req",   32'(imem_req),   32'd0);
    check32("rst_imem_addr",  imem_addr,       RESET_PC);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_occupancy",  32'(occupancy),  32'd0);
    check32("rst_inst_data",  inst_data,       32'd0);
    check32("rst_inst_pc",    inst_pc,         32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] wrapExp [3];
    logic [31:0] rpc;
    int          got;
    bit          found;
    bit          rdy, redir;

    wrapExp[0] = 32'hFFFF_FFFC;
    wrapExp[1] = 32'h0000_0000;
    wrapExp[2] = 32'h0000_0004;

    @(negedge clk);

    // Streaming from reset
    doReset();
    applyStimulus(1, 0, 0);
    check32("c0_req",  32'(sReq), 32'd1);
    check32("c0_addr", sAddr,     32'h8000_0000);
    applyStimulus(1, 0, 0);
    check32("c1_valid", 32'(sValid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0);
      check32("stream_valid", 32'(sValid), 32'd1);
      check32("stream_pc",    sPc,         RESET_PC + 32'(4 * k));
      check32("stream_data",  sData,       ~(RESET_PC + 32'(4 * k)));
    end

    // Backpressure fills the FIFO, then drains in order
    doReset();
    repeat (8) applyStimulus(0, 0, 0);
    check32("full_occ", 32'(sOcc), 32'd4);
    check32("full_req", 32'(sReq), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0);
      check32("drain_pc", sPc, RESET_PC + 32'(4 * k));
      if (sReq && !found) begin
        check32("resume_addr", sAddr, 32'h8000_0010);
        found = 1'b1;
      end
    end
    check32("resume_seen", 32'(found), 32'd1);
    applyStimulus(1, 0, 0);
    check32("after_drain_pc", sPc, 32'h8000_0010);

    // Redirect with a read in flight and three buffered words
    doReset();
    repeat (4) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 32'h8000_0100);
    check32("redir_occ_before", 32'(sOcc), 32'd3);
    check32("redir_req_same",   32'(sReq), 32'd0);
    applyStimulus(1, 0, 0);
    check32("redir_occ_after", 32'(sOcc), 32'd0);
    check32("redir_req",       32'(sReq), 32'd1);
    check32("redir_addr",      sAddr,     32'h8000_0100);
    applyStimulus(1, 0, 0);
    check32("redir_gap_valid", 32'(sValid), 32'd0);
    applyStimulus(1, 0, 0);
    check32("redir_first_valid", 32'(sValid), 32'd1);
    check32("redir_first_pc",    sPc,         32'h8000_0100);

    // Redirect coinciding with a head handshake, unaligned target
    doReset();
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 32'h8000_0206);
    check32("hs_valid", 32'(sValid), 32'd1);
    check32("hs_pc",    sPc,         32'h8000_0004);
    applyStimulus(1, 0, 0);
    check32("unal_addr", sAddr, 32'h8000_0204);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    check32("unal_pc", sPc, 32'h8000_0204);

    // Address wrap
    applyStimulus(1, 1, 32'hFFFF_FFFC);
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      applyStimulus(1, 0, 0);
      if (sValid) begin
        check32("wrap_pc", sPc, wrapExp[got]);
        got++;
      end
    end
    check32("wrap_count", 32'(got), 32'd3);

    // Reset pulse mid-stream
    doReset();
    repeat (4) applyStimulus(0, 0, 0);
    check32("pulse_occ", 32'(sOcc), 32'd2);
    doReset();
    applyStimulus(1, 0, 0);
    check32("pulse_restart_req",  32'(sReq), 32'd1);
    check32("pulse_restart_addr", sAddr,     RESET_PC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        rdy   = ($urandom_range(0, 3) != 0);
        redir = ($urandom_range(0, 24) == 0);
        rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
        applyStimulus(rdy, redir, rpc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
